// File: rtl/bounce_pkg.sv
// bounce_pkg: shared state encoding, LFSR polynomial and default parameters for bounce_gen.
package bounce_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int BOUNCE_CYCLES_DEF = 16;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int HOLD_W_DEF = 2;
    localparam logic [15:0] SEED_DEF = 16'hACE1;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), advancing only while en is high.
module lfsr16 import bounce_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] init;
    // An all-zero state would lock up, so a zero seed starts from 1 instead.
    assign init = (seed == 16'h0000) ? 16'h0001 : seed;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= init;
        else if (en)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: emulates a bouncing mechanical contact; each level change produces a
// pseudo-random toggle burst, a stable settle window, then a one-cycle done pulse.
module bounce_gen import bounce_pkg::*; #(
    parameter int          BOUNCE_CYCLES = BOUNCE_CYCLES_DEF,
    parameter int          SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int          HOLD_W        = HOLD_W_DEF,
    parameter logic [15:0] SEED          = SEED_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic noisy,
    output logic busy,
    output logic done
);
    localparam int BW = $clog2(BOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    logic [1:0]        state;
    logic              target, level_q, retarget;
    logic [BW-1:0]     bounce_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       lfsr;
    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state == BOUNCE),
        .seed  (SEED),
        .q     (lfsr)
    );
    assign busy = (state == BOUNCE) || (state == SETTLE);
    // A request that differs from the level in progress restarts the burst, even on a terminal count.
    assign retarget = (state == IDLE) ? (level_in != level_q) : busy && (level_in != target);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            noisy      <= 1'b0;
            done       <= 1'b0;
            target     <= 1'b0;
            level_q    <= 1'b0;
            bounce_cnt <= '0;
            settle_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (retarget) begin
                state      <= BOUNCE;
                target     <= level_in;
                noisy      <= level_in;
                bounce_cnt <= BW'(BOUNCE_CYCLES - 1);
                hold_cnt   <= lfsr[HOLD_W-1:0];
            end else if (state == BOUNCE) begin
                if (bounce_cnt == '0) begin
                    state      <= SETTLE;
                    noisy      <= target;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                end else begin
                    bounce_cnt <= bounce_cnt - BW'(1);
                    if (hold_cnt == '0) begin
                        noisy    <= ~noisy;
                        hold_cnt <= lfsr[HOLD_W-1:0];
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
            end else if (state == SETTLE) begin
                noisy <= target;
                if (settle_cnt == '0) begin
                    state   <= IDLE;
                    level_q <= target;
                    done    <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
            end else begin
                state <= IDLE;
                noisy <= level_q;
            end
        end
    end
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed vectors plus hand-written multi-cycle sequences for bounce_gen.
module tb_bounce_gen;
    logic clk = 1'b0;
    logic reset, level_in;
    logic noisy, busy, done;
    logic noisy0, busy0, done0;
    int n_chk = 0, n_pass = 0;
    logic [15:0] m_lfsr;
    logic exp_n [0:16];
    logic wave [0:25];
    logic wave_a [0:25];
    logic db_out;
    int db_cnt;

    always #5 clk = ~clk;

    bounce_gen dut (.clk(clk), .reset(reset), .level_in(level_in), .noisy(noisy), .busy(busy), .done(done));
    bounce_gen #(.SEED(16'h0000)) dut0 (.clk(clk), .reset(reset), .level_in(level_in), .noisy(noisy0), .busy(busy0), .done(done0));

    // Consumer-side debouncer: follows noisy only after 6 consecutive disagreeing clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_out <= 1'b0;
            db_cnt <= 0;
        end else if (noisy == db_out) begin
            db_cnt <= 0;
        end else if (db_cnt == 5) begin
            db_out <= noisy;
            db_cnt <= 0;
        end else begin
            db_cnt <= db_cnt + 1;
        end
    end

    typedef struct {
        logic rst;
        logic lvl;
        int   n;
        logic busy;
        logic done;
        logic noisy;
    } vec_t;
    vec_t vecs [0:2];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Expected noisy for the 17 BOUNCE-phase samples of a transition toward tgt.
    task automatic predict(input logic tgt);
        logic [1:0] h;
        logic n;
        h = m_lfsr[1:0];
        n = tgt;
        exp_n[0] = n;
        for (int k = 1; k <= 15; k++) begin
            if (h == 2'd0) begin
                n = ~n;
                h = m_lfsr[1:0];
            end else begin
                h = h - 2'd1;
            end
            m_lfsr = lstep(m_lfsr);
            exp_n[k] = n;
        end
        m_lfsr = lstep(m_lfsr);
        exp_n[16] = tgt;
    endtask

    task automatic profile(input logic tgt, input int last_k, input string tag);
        int tog;
        logic prev;
        tog = 0;
        prev = tgt;
        for (int k = 0; k <= last_k; k++) begin
            step();
            chk($sformatf("%s noisy k=%0d", tag, k), noisy, (k <= 16) ? exp_n[k] : tgt);
            chk($sformatf("%s busy k=%0d", tag, k), busy, k < 24);
            chk($sformatf("%s done k=%0d", tag, k), done, k == 24);
            if (k >= 1 && k <= 15 && noisy != prev) tog++;
            prev = noisy;
            wave[k] = noisy;
        end
        if (last_k >= 15) chk({tag, " toggles>=3"}, tog >= 3, 1);
    endtask

    task automatic apply_vec(input int i);
        reset = vecs[i].rst;
        level_in = vecs[i].lvl;
        for (int c = 0; c < vecs[i].n; c++) begin
            step();
            chk($sformatf("vec%0d busy c=%0d", i, c), busy, vecs[i].busy);
            chk($sformatf("vec%0d done c=%0d", i, c), done, vecs[i].done);
            chk($sformatf("vec%0d noisy c=%0d", i, c), noisy, vecs[i].noisy);
        end
    endtask

    initial begin
        logic [15:0] l1;
        vecs[0] = '{rst: 1'b1, lvl: 1'b0, n: 3,  busy: 1'b0, done: 1'b0, noisy: 1'b0};
        vecs[1] = '{rst: 1'b0, lvl: 1'b0, n: 50, busy: 1'b0, done: 1'b0, noisy: 1'b0};
        vecs[2] = '{rst: 1'b0, lvl: 1'b1, n: 5,  busy: 1'b0, done: 1'b0, noisy: 1'b1};
        reset = 1'b1;
        level_in = 1'b0;
        #1;
        chk("seed_ace1", dut.u_lfsr.q, 16'hACE1);
        chk("seed_zero", dut0.u_lfsr.q, 16'h0001);
        apply_vec(0);
        apply_vec(1);

        m_lfsr = 16'hACE1;
        level_in = 1'b1;
        predict(1'b1);
        profile(1'b1, 25, "rise");
        for (int k = 0; k <= 25; k++) wave_a[k] = wave[k];
        l1 = 16'h0001;
        for (int k = 0; k < 16; k++) l1 = lstep(l1);
        chk("seed0_advance", dut0.u_lfsr.q, l1);
        chk("seed0_done_noisy", noisy0, 1'b1);
        apply_vec(2);
        for (int c = 0; c < 200; c++) begin
            step();
            if (db_out !== 1'b1 || c == 199) chk($sformatf("debounce c=%0d", c), db_out, 1'b1);
        end

        reset = 1'b1;
        level_in = 1'b0;
        step();
        step();
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        level_in = 1'b1;
        predict(1'b1);
        profile(1'b1, 20, "abort_rise");
        for (int k = 0; k <= 20; k++) chk($sformatf("repeat_wave k=%0d", k), wave[k], wave_a[k]);
        level_in = 1'b0;
        predict(1'b0);
        profile(1'b0, 25, "abort_fall");

        level_in = 1'b1;
        predict(1'b1);
        profile(1'b1, 10, "rst_bounce");
        reset = 1'b1;
        #1;
        chk("rst_now noisy", noisy, 1'b0);
        chk("rst_now busy", busy, 1'b0);
        chk("rst_now done", done, 1'b0);
        step();
        chk("rst_hold done", done, 1'b0);
        step();
        chk("rst_hold busy", busy, 1'b0);
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        predict(1'b1);
        profile(1'b1, 25, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
